// File: rtl/if_stage_mo.sv
// Multi-outstanding instruction-fetch stage with a credit-checked instruction buffer and a
// discard counter for squashing stale returns. Defining IF_BYPASS_EN enables same-cycle return bypass.
module if_stage_mo #(
   parameter int          MAX_OUTSTANDING = 2,
   parameter int          IBUF_DEPTH      = 4,
   parameter logic [31:0] RESET_PC        = 32'h1c000000
) (
   input  logic        clk,
   input  logic        resetn,
   output logic        inst_sram_req,
   output logic        inst_sram_wr,
   output logic [3:0]  inst_sram_wstrb,
   output logic [31:0] inst_sram_wdata,
   output logic [1:0]  inst_sram_size,
   output logic [31:0] inst_sram_addr,
   input  logic        inst_sram_addr_ok,
   input  logic        inst_sram_data_ok,
   input  logic [31:0] inst_sram_rdata,
   input  logic        ds_allowin,
   input  logic        br_stall,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        wb_ex,
   input  logic [31:0] ex_entry,
   input  logic        ertn_flush,
   input  logic [31:0] ertn_entry,
   output logic        fs_to_ds_valid,
   output logic [64:0] fs_to_ds_bus
);

   localparam int CW = $clog2(MAX_OUTSTANDING + 1);
   localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int BW = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;
   localparam int NW = $clog2(IBUF_DEPTH + 1);
   localparam int SW = NW + 1;

   logic [31:0]   fetch_pc;
   logic [CW-1:0] inflight;
   logic [CW-1:0] discard_cnt;
   logic          halt;

   logic [31:0]   pc_fifo [MAX_OUTSTANDING];
   logic [PW-1:0] pc_wr;
   logic [PW-1:0] pc_rd;

   logic [64:0]   ibuf [IBUF_DEPTH];
   logic [BW-1:0] ib_wr;
   logic [BW-1:0] ib_rd;
   logic [NW-1:0] ib_count;

   logic          redirect;
   logic [31:0]   redirect_pc;
   logic          pc_aligned;
   logic          credit_ok;
   logic          fire;
   logic          ret_keep;
   logic          ret_push;
   logic          adef_push;
   logic          ib_push;
   logic          ib_pop;
   logic          ib_empty;
   logic          ib_full;
   logic [64:0]   ib_wdata;
   logic [31:0]   pc_head;

   function automatic logic [PW-1:0] pc_ptr_next(input logic [PW-1:0] p);
      return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
   endfunction

   assign inst_sram_wr    = 1'b0;
   assign inst_sram_wstrb = 4'h0;
   assign inst_sram_wdata = 32'h0;
   assign inst_sram_size  = 2'b10;
   assign inst_sram_addr  = fetch_pc;

   assign redirect    = wb_ex | ertn_flush | br_taken;
   assign redirect_pc = wb_ex ? ex_entry : (ertn_flush ? ertn_entry : br_target);
   assign pc_aligned  = (fetch_pc[1:0] == 2'b00);
   assign ib_empty    = (ib_count == '0);
   assign ib_full     = (ib_count == NW'(IBUF_DEPTH));
   assign pc_head     = pc_fifo[pc_rd];

   // Every issued request must already own an ibuf slot, so returns can never overflow it.
   assign credit_ok = (inflight < CW'(MAX_OUTSTANDING)) &&
                      ((SW'(ib_count) + SW'(inflight)) < SW'(IBUF_DEPTH));

   assign inst_sram_req = resetn & ~redirect & ~br_stall & ~halt & pc_aligned & credit_ok;
   assign fire          = inst_sram_req & inst_sram_addr_ok;

   assign ret_keep  = inst_sram_data_ok & (discard_cnt == '0) & ~redirect;
   assign adef_push = ~pc_aligned & ~halt & ~redirect & (inflight == '0) &
                      (discard_cnt == '0) & ~ib_full;

`ifdef IF_BYPASS_EN
   logic bypass;
   assign bypass         = ret_keep & ib_empty;
   assign fs_to_ds_valid = ~ib_empty | bypass;
   assign fs_to_ds_bus   = bypass ? {1'b0, inst_sram_rdata, pc_head} : ibuf[ib_rd];
   assign ret_push       = ret_keep & ~(bypass & ds_allowin);
`else
   assign fs_to_ds_valid = ~ib_empty;
   assign fs_to_ds_bus   = ibuf[ib_rd];
   assign ret_push       = ret_keep;
`endif

   assign ib_pop   = ~ib_empty & ds_allowin;
   assign ib_push  = ret_push | adef_push;
   assign ib_wdata = ret_push ? {1'b0, inst_sram_rdata, pc_head} : {1'b1, 32'h0, fetch_pc};

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         fetch_pc <= RESET_PC;
         halt     <= 1'b0;
      end else if (redirect) begin
         fetch_pc <= redirect_pc;
         halt     <= 1'b0;
      end else begin
         if (fire)
            fetch_pc <= fetch_pc + 32'd4;
         if (adef_push)
            halt <= 1'b1;
      end
   end

   // After a redirect every return still in flight is stale, including any arriving this cycle.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         inflight    <= '0;
         discard_cnt <= '0;
      end else begin
         inflight <= inflight + CW'(fire) - CW'(inst_sram_data_ok);
         if (redirect)
            discard_cnt <= inflight + CW'(fire) - CW'(inst_sram_data_ok);
         else if (inst_sram_data_ok && (discard_cnt != '0))
            discard_cnt <= discard_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pc_wr <= '0;
         pc_rd <= '0;
      end else begin
         if (fire)
            pc_wr <= pc_ptr_next(pc_wr);
         if (inst_sram_data_ok)
            pc_rd <= pc_ptr_next(pc_rd);
      end
   end

   always_ff @(posedge clk) begin
      if (fire)
         pc_fifo[pc_wr] <= fetch_pc;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ib_wr    <= '0;
         ib_rd    <= '0;
         ib_count <= '0;
      end else if (redirect) begin
         ib_wr    <= '0;
         ib_rd    <= '0;
         ib_count <= '0;
      end else begin
         if (ib_push)
            ib_wr <= ib_wr + 1'b1;
         if (ib_pop)
            ib_rd <= ib_rd + 1'b1;
         ib_count <= ib_count + NW'(ib_push) - NW'(ib_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (ib_push && !redirect)
         ibuf[ib_wr] <= ib_wdata;
   end

endmodule

// File: tb/tb_if_stage_mo.sv
// Scoreboard bench for if_stage_mo: an in-order SRAM-like bridge model feeds returns,
// and the expected {adef, inst, pc} stream is compared whenever decode consumes an entry.
module tb_if_stage_mo;

   localparam logic [31:0] RESET_PC = 32'h1c000000;
   localparam int          MAXO     = 2;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        inst_sram_req;
   logic        inst_sram_wr;
   logic [3:0]  inst_sram_wstrb;
   logic [31:0] inst_sram_wdata;
   logic [1:0]  inst_sram_size;
   logic [31:0] inst_sram_addr;
   logic        inst_sram_addr_ok = 1'b0;
   logic        inst_sram_data_ok = 1'b0;
   logic [31:0] inst_sram_rdata = 32'h0;
   logic        ds_allowin = 1'b1;
   logic        br_stall = 1'b0;
   logic        br_taken = 1'b0;
   logic [31:0] br_target = 32'h0;
   logic        wb_ex = 1'b0;
   logic [31:0] ex_entry = 32'h0;
   logic        ertn_flush = 1'b0;
   logic [31:0] ertn_entry = 32'h0;
   logic        fs_to_ds_valid;
   logic [64:0] fs_to_ds_bus;

   int          n_assert = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          lat = 1;
   bit          ack_en = 1'b1;
   int          discard = 0;
   int          consumed = 0;
   int          max_os = 0;
   logic [31:0] os_addr [$];
   int          os_due [$];
   logic [64:0] exp_q [$];
   logic        req_s;
   logic [31:0] addr_s;
   logic        valid_s;
   logic [64:0] bus_s;

   always #5 clk = ~clk;

   if_stage_mo #(
      .MAX_OUTSTANDING(MAXO),
      .IBUF_DEPTH(4),
      .RESET_PC(RESET_PC)
   ) dut (
      .clk(clk),
      .resetn(resetn),
      .inst_sram_req(inst_sram_req),
      .inst_sram_wr(inst_sram_wr),
      .inst_sram_wstrb(inst_sram_wstrb),
      .inst_sram_wdata(inst_sram_wdata),
      .inst_sram_size(inst_sram_size),
      .inst_sram_addr(inst_sram_addr),
      .inst_sram_addr_ok(inst_sram_addr_ok),
      .inst_sram_data_ok(inst_sram_data_ok),
      .inst_sram_rdata(inst_sram_rdata),
      .ds_allowin(ds_allowin),
      .br_stall(br_stall),
      .br_taken(br_taken),
      .br_target(br_target),
      .wb_ex(wb_ex),
      .ex_entry(ex_entry),
      .ertn_flush(ertn_flush),
      .ertn_entry(ertn_entry),
      .fs_to_ds_valid(fs_to_ds_valid),
      .fs_to_ds_bus(fs_to_ds_bus)
   );

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h13572468;
   endfunction

   task automatic checkOutput(input string tag, input logic [64:0] obs, input logic [64:0] expv);
      n_assert++;
      assert (obs === expv)
      else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // One clock cycle: bridge responds, outputs are sampled, the scoreboard is updated.
   task automatic applyStimulus();
      logic [31:0] a;
      logic        redir;
      inst_sram_addr_ok = ack_en;
      if (os_addr.size() > 0 && os_due[0] <= cyc) begin
         inst_sram_data_ok = 1'b1;
         inst_sram_rdata   = inst_of(os_addr[0]);
      end else begin
         inst_sram_data_ok = 1'b0;
         inst_sram_rdata   = 32'hdeadbeef;
      end
      #1;
      req_s   = inst_sram_req;
      addr_s  = inst_sram_addr;
      valid_s = fs_to_ds_valid;
      bus_s   = fs_to_ds_bus;
      redir   = wb_ex | ertn_flush | br_taken;
      if (inst_sram_data_ok) begin
         a = os_addr.pop_front();
         void'(os_due.pop_front());
         if (discard > 0)
            discard--;
         else if (!redir)
            exp_q.push_back({1'b0, inst_of(a), a});
      end
      if (valid_s && ds_allowin) begin
         consumed++;
         if (exp_q.size() == 0)
            checkOutput("spurious_output", 65'(valid_s), 65'(0));
         else
            checkOutput("fs_to_ds_bus", bus_s, exp_q.pop_front());
      end
      if (redir) begin
         exp_q.delete();
         discard = os_addr.size();
      end
      if (req_s && inst_sram_addr_ok) begin
         os_addr.push_back(addr_s);
         os_due.push_back(cyc + lat);
      end
      if (os_addr.size() > max_os)
         max_os = os_addr.size();
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic drain(input string tag);
      ack_en     = 1'b0;
      ds_allowin = 1'b1;
      for (int i = 0; i < 60 && (os_addr.size() > 0 || exp_q.size() > 0); i++)
         applyStimulus();
      checkOutput(tag, 65'(exp_q.size() + os_addr.size()), 65'(0));
   endtask

   initial begin
      int c0;
      int reqs;

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      checkOutput("reset_req", 65'(inst_sram_req), 65'(0));
      checkOutput("reset_valid", 65'(fs_to_ds_valid), 65'(0));
      checkOutput("tie_offs", {inst_sram_wr, inst_sram_wstrb, inst_sram_wdata, inst_sram_size},
                  {1'b0, 4'h0, 32'h0, 2'b10});
      resetn = 1'b1;

      // Streaming: first request at RESET_PC, then one instruction per cycle
      ack_en = 1'b1; lat = 1; ds_allowin = 1'b1;
      applyStimulus();
      checkOutput("first_req", {req_s, addr_s}, {1'b1, RESET_PC});
      repeat (4) applyStimulus();
      c0 = consumed;
      repeat (10) applyStimulus();
      checkOutput("throughput", 65'(consumed - c0), 65'(10));

      // Decode stall fills the buffer and stops requests
      ds_allowin = 1'b0;
      repeat (10) applyStimulus();
      checkOutput("stall_req", 65'(req_s), 65'(0));
      checkOutput("stall_fill", 65'(exp_q.size()), 65'(4));
      ds_allowin = 1'b1;
      repeat (15) applyStimulus();
      drain("drain_after_stall");

      // Two in flight, branch with a same-cycle return
      ack_en = 1'b1; lat = 3;
      for (int i = 0; i < 10 && os_addr.size() < 2; i++) applyStimulus();
      checkOutput("two_in_flight", 65'(os_addr.size()), 65'(2));
      for (int i = 0; i < 10 && os_addr.size() > 0 && os_due[0] > cyc; i++) applyStimulus();
      br_taken = 1'b1; br_target = 32'h1c000100;
      applyStimulus();
      br_taken = 1'b0; lat = 1;
      applyStimulus();
      checkOutput("branch_req", {req_s, addr_s}, {1'b1, 32'h1c000100});
      repeat (10) applyStimulus();

      // Exception beats branch
      wb_ex = 1'b1; ex_entry = 32'h1c000200; br_taken = 1'b1; br_target = 32'h1c000300;
      applyStimulus();
      wb_ex = 1'b0; br_taken = 1'b0;
      applyStimulus();
      checkOutput("wb_ex_priority", {req_s, addr_s}, {1'b1, 32'h1c000200});
      repeat (6) applyStimulus();

      // Ertn beats branch
      ertn_flush = 1'b1; ertn_entry = 32'h1c000400; br_taken = 1'b1; br_target = 32'h1c000300;
      applyStimulus();
      ertn_flush = 1'b0; br_taken = 1'b0;
      applyStimulus();
      checkOutput("ertn_priority", {req_s, addr_s}, {1'b1, 32'h1c000400});
      repeat (6) applyStimulus();

      // Misaligned target: address fault entry, then halt until an exception redirect
      br_taken = 1'b1; br_target = 32'h1c000102;
      applyStimulus();
      br_taken = 1'b0;
      exp_q.push_back({1'b1, 32'h0, 32'h1c000102});
      reqs = 0;
      repeat (12) begin
         applyStimulus();
         if (req_s) reqs++;
      end
      checkOutput("adef_no_req", 65'(reqs), 65'(0));
      checkOutput("adef_delivered", 65'(exp_q.size()), 65'(0));
      wb_ex = 1'b1; ex_entry = 32'h1c000500;
      applyStimulus();
      wb_ex = 1'b0;
      applyStimulus();
      checkOutput("adef_restart", {req_s, addr_s}, {1'b1, 32'h1c000500});

      // Slow returns keep in-order pairing and the outstanding cap
      lat = 5;
      repeat (30) applyStimulus();
      drain("drain_slow");
      checkOutput("max_outstanding", 65'(max_os), 65'(MAXO));

      // Reset in the middle of a transfer
      ack_en = 1'b1; lat = 2; ds_allowin = 1'b1;
      repeat (6) applyStimulus();
      resetn = 1'b0;
      #1;
      checkOutput("midreset_req", 65'(inst_sram_req), 65'(0));
      checkOutput("midreset_valid", 65'(fs_to_ds_valid), 65'(0));
      os_addr.delete(); os_due.delete(); exp_q.delete(); discard = 0;
      @(negedge clk);
      resetn = 1'b1;
      applyStimulus();
      checkOutput("midreset_restart", {req_s, addr_s}, {1'b1, RESET_PC});
      repeat (8) applyStimulus();
      drain("drain_final");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
